// File: rtl/tmc_capture_pkg.sv
// Shared types and default widths for the circular pre/post-trigger capture engine.
package tmc_capture_pkg;

  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/tmc_capture_wrport.sv
// Registered single-port RAM write stage: one accepted beat becomes one write
// strobe on the following cycle.
module tmc_capture_wrport
  import tmc_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_write
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q;

  // NOTE: reset is sampled on the clock edge, and every register here uses <=
  // so all flops update together and reset drops a pending strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else begin
      write_q <= wr_en;
      if (wr_en) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
      end
    end
  end

  assign mem_address   = addr_q;
  assign mem_writedata = data_q;
  assign mem_write     = write_q;

endmodule

// File: rtl/tmc_capture_ring_writer.sv
// Circular pre/post-trigger capture engine writing accepted samples into a
// 2^ADDR_W-word on-chip RAM; FSM and counters live here, the write port below.
module tmc_capture_ring_writer
  import tmc_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   post_count,
  input  logic                trig,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  output logic                busy,
  output logic                done,
  output logic                wrapped,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W-1:0]   wr_ptr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              wrapped_q, wrapped_d;
  logic              accept;

  // abort gates in_ready, so an aborting cycle can never produce a write
  assign in_ready = ((state_q == PRE) || (state_q == POST)) && !abort;
  assign accept   = in_valid && in_ready;

  // NOTE: every signal written here gets its default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    remaining_d = remaining_q;
    wrapped_d   = wrapped_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (&wr_ptr_q) wrapped_d = 1'b1;
    end

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d     = PRE;
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            remaining_d = post_count;
          end
        end
        PRE: begin
          if (accept && trig) begin
            trig_addr_d = wr_ptr_q;
            state_d     = (remaining_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (accept) begin
            remaining_d = remaining_q - ADDR_W'(1);
            if (remaining_q == ADDR_W'(1)) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      remaining_q <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      remaining_q <= remaining_d;
      wrapped_q   <= wrapped_d;
    end
  end

  tmc_capture_wrport #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wrport (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_en         (accept),
    .wr_addr       (wr_ptr_q),
    .wr_data       (in_data),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_write     (mem_write)
  );

  assign mem_chipselect = mem_write;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

  assign busy      = (state_q == PRE) || (state_q == POST);
  assign done      = (state_q == DONE);
  assign wrapped   = wrapped_q;
  assign trig_addr = trig_addr_q;
  assign wr_ptr    = wr_ptr_q;

endmodule
